// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD sequencer.
//   - lcd_state_t : sequencer / bus-cycle state encoding
//   - init command bytes, line base addresses, default timing values
//   - helpers: init_cmd() selects the n-th power-on command,
//              is_long_cmd() flags clear/home commands that need LONG_WAIT
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WRAP
  } lcd_state_t;

  // Power-on command sequence: 8-bit/2-line, display on, clear, entry mode.
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  // DDRAM set-address commands for the start of each display line.
  localparam logic [7:0] LINE0_BASE = 8'h80;
  localparam logic [7:0] LINE1_BASE = 8'hC0;

  localparam int DEF_PWR_WAIT  = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_EN_CYC    = 2;
  localparam int DEF_HOLD_CYC  = 4;
  localparam int DEF_LONG_WAIT = 16;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) take far longer inside the LCD.
  function automatic logic is_long_cmd(input logic rs_bit, input logic [7:0] b);
    return !rs_bit && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if: host request handshake into the LCD sequencer.
//   req_valid : host request present
//   req_rs    : 1 = character, 0 = command
//   req_data  : character code or command byte
//   req_ready : request accepted on clk edge when req_valid && req_ready
// master = host side, slave = sequencer side.
interface lcd_sequencer_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: one LCD write cycle timing engine.
// On start (while idle) the byte/rs are latched onto the bus, then:
//   SETUP : en=0 for 1+SETUP_CYC cycles (latch cycle plus setup time)
//   PULSE : en=1 for EN_CYC cycles
//   HOLD  : en=0 for HOLD_CYC, or LONG_WAIT when long_wait was set at start
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, cmd_byte,
//   cmd_rs, long_wait     : launch request and its payload
//   done                  : high during the last HOLD cycle
//   idle                  : engine ready to accept start
//   en, rs, data          : registered LCD bus pins
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int LONG_WAIT = DEF_LONG_WAIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_rs,
  input  logic       long_wait,
  output logic       done,
  output logic       idle,
  output logic       en,
  output logic       rs,
  output logic [7:0] data
);

  lcd_state_t  phase_reg, phase_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        long_reg, long_next;
  logic        en_reg, en_next;
  logic        rs_reg, rs_next;
  logic [7:0]  data_reg, data_next;
  logic [15:0] hold_last;

  assign hold_last = long_reg ? 16'(LONG_WAIT - 1) : 16'(HOLD_CYC - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= IDLE;
      cnt_reg   <= '0;
      long_reg  <= 1'b0;
      en_reg    <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      long_reg  <= long_next;
      en_reg    <= en_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg + 16'd1;
    long_next  = long_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    done       = 1'b0;
    case (phase_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          phase_next = SETUP;
          long_next  = long_wait;
          rs_next    = cmd_rs;
          data_next  = cmd_byte;
        end
      end
      // Counts 0..SETUP_CYC: the first cycle is the bus latch cycle itself.
      SETUP: begin
        if (cnt_reg == 16'(SETUP_CYC)) begin
          phase_next = PULSE;
          cnt_next   = '0;
        end
      end
      PULSE: begin
        if (cnt_reg == 16'(EN_CYC - 1)) begin
          phase_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (cnt_reg == hold_last) begin
          phase_next = IDLE;
          cnt_next   = '0;
          done       = 1'b1;
        end
      end
      default: begin
        phase_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    en_next = (phase_next == PULSE);
  end

  assign idle = (phase_reg == IDLE);
  assign en   = en_reg;
  assign rs   = rs_reg;
  assign data = data_reg;

endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: power-up/init sequencing, host handshake and cursor
// tracking for a 2x16 character LCD driven in 8-bit write-only mode.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   host        : request handshake (lcd_sequencer_if.slave)
//   data, rs,
//   rw, en      : LCD pins (rw tied low)
//   init_done   : power-on command sequence finished
//   busy        : sequencer not in IDLE
// The SETUP state here stands for "a bus cycle is in flight"; the
// SETUP/PULSE/HOLD detail is sequenced inside lcd_bus_cycle.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int PWR_WAIT  = DEF_PWR_WAIT,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int LONG_WAIT = DEF_LONG_WAIT
) (
  input  logic            clk,
  input  logic            reset,
  lcd_sequencer_if.slave  host,
  output logic [7:0]      data,
  output logic            rs,
  output logic            rw,
  output logic            en,
  output logic            init_done,
  output logic            busy
);

  lcd_state_t  state_reg, state_next;
  logic [15:0] pwr_cnt_reg, pwr_cnt_next;
  logic [1:0]  init_idx_reg, init_idx_next;
  logic        init_done_reg, init_done_next;
  logic [3:0]  col_reg, col_next;
  logic        line_reg, line_next;
  logic        wrap_reg, wrap_next;

  logic        start;
  logic [7:0]  cmd_byte;
  logic        cmd_rs;
  logic        long_wait;
  logic        eng_done;
  logic        eng_idle;
  logic        accept;

  assign accept = (state_reg == IDLE) && init_done_reg && host.req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PWRUP;
      pwr_cnt_reg   <= '0;
      init_idx_reg  <= '0;
      init_done_reg <= 1'b0;
      col_reg       <= '0;
      line_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pwr_cnt_reg   <= pwr_cnt_next;
      init_idx_reg  <= init_idx_next;
      init_done_reg <= init_done_next;
      col_reg       <= col_next;
      line_reg      <= line_next;
      wrap_reg      <= wrap_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pwr_cnt_next   = pwr_cnt_reg;
    init_idx_next  = init_idx_reg;
    init_done_next = init_done_reg;
    col_next       = col_reg;
    line_next      = line_reg;
    wrap_next      = wrap_reg;
    start          = 1'b0;
    cmd_byte       = host.req_data;
    cmd_rs         = host.req_rs;
    case (state_reg)
      PWRUP: begin
        pwr_cnt_next = pwr_cnt_reg + 16'd1;
        if (pwr_cnt_reg == 16'(PWR_WAIT - 1)) begin
          state_next   = INIT;
          pwr_cnt_next = '0;
        end
      end
      // Launch the next init command whenever the engine is idle; the
      // engine's done pulse advances the index.
      INIT: begin
        cmd_byte = init_cmd(init_idx_reg);
        cmd_rs   = 1'b0;
        start    = eng_idle;
        if (eng_done) begin
          if (init_idx_reg == 2'd3) begin
            init_done_next = 1'b1;
            state_next     = IDLE;
          end else begin
            init_idx_next = init_idx_reg + 2'd1;
          end
        end
      end
      IDLE: begin
        if (accept) begin
          start      = 1'b1;
          state_next = SETUP;
          if (host.req_rs) begin
            // col wraps to 0 naturally; the line change happens in WRAP.
            col_next  = col_reg + 4'd1;
            wrap_next = (col_reg == 4'd15);
          end else if (is_long_cmd(1'b0, host.req_data)) begin
            col_next  = '0;
            line_next = 1'b0;
          end else if (host.req_data[7]) begin
            line_next = host.req_data[6];
            col_next  = host.req_data[3:0];
          end
        end
      end
      SETUP: begin
        if (eng_done) begin
          state_next = wrap_reg ? WRAP : IDLE;
          wrap_next  = 1'b0;
        end
      end
      // Move the LCD address to the start of the other line.
      WRAP: begin
        cmd_byte   = line_reg ? LINE0_BASE : LINE1_BASE;
        cmd_rs     = 1'b0;
        start      = 1'b1;
        line_next  = ~line_reg;
        col_next   = '0;
        state_next = SETUP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign long_wait      = is_long_cmd(cmd_rs, cmd_byte);
  assign host.req_ready = (state_reg == IDLE) && init_done_reg;
  assign busy           = (state_reg != IDLE);
  assign init_done      = init_done_reg;
  assign rw             = 1'b0;

  lcd_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .EN_CYC    (EN_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .LONG_WAIT (LONG_WAIT)
  ) u_bus_cycle (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmd_byte  (cmd_byte),
    .cmd_rs    (cmd_rs),
    .long_wait (long_wait),
    .done      (eng_done),
    .idle      (eng_idle),
    .en        (en),
    .rs        (rs),
    .data      (data)
  );

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: scoreboard bench for lcd_sequencer.
// The driver issues host requests and a display-level model (cursor column
// and line as integers) predicts every LCD write the host request implies;
// a monitor pops predictions on each en pulse.
module tb_lcd_sequencer;

  localparam int PWR_WAIT  = 8;
  localparam int SETUP_CYC = 1;
  localparam int EN_CYC    = 2;
  localparam int HOLD_CYC  = 4;
  localparam int LONG_WAIT = 16;
  localparam int SHORT_LEN = 1 + SETUP_CYC + EN_CYC + HOLD_CYC;
  localparam int LONG_LEN  = 1 + SETUP_CYC + EN_CYC + LONG_WAIT;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;   // expected en-rise edge, -1 = not timed
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, init_done, busy;

  lcd_sequencer_if bus();

  lcd_sequencer #(
    .PWR_WAIT(PWR_WAIT), .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC),
    .HOLD_CYC(HOLD_CYC), .LONG_WAIT(LONG_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .host(bus),
    .data(lcd_data), .rs(lcd_rs), .rw(lcd_rw), .en(lcd_en),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   m_col = 0;
  int   m_line = 0;
  int   rw_bad = 0;
  int   stab_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Display-level model: returns cycles until the host may send again.
  function automatic int model_accept(input logic r, input logic [7:0] d, input int edge_n);
    sb.push_back(exp_t'{r, d, edge_n + 2});
    if (r) begin
      m_col++;
      if (m_col == 16) begin
        sb.push_back(exp_t'{1'b0, (m_line == 1) ? 8'h80 : 8'hC0, -1});
        m_line = 1 - m_line;
        m_col  = 0;
        return SHORT_LEN + 1 + SHORT_LEN;
      end
      return SHORT_LEN;
    end
    if (d == 8'h01 || d == 8'h02 || d == 8'h03) begin
      m_col  = 0;
      m_line = 0;
      return LONG_LEN;
    end
    if (d[7]) begin
      m_line = int'(d[6]);
      m_col  = int'(d[3:0]);
    end
    return SHORT_LEN;
  endfunction

  // Monitor: one line per observed LCD write.
  logic [7:0] cur_data;
  logic       cur_rs;
  bit         in_pulse = 0;
  int         width = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_pulse = 0;
        width    = 0;
      end else begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (lcd_en && !in_pulse) begin
          in_pulse = 1;
          width    = 1;
          cur_data = lcd_data;
          cur_rs   = lcd_rs;
          $display("lcd write rs=%0d data=0x%02h at cycle %0d", lcd_rs, lcd_data, cyc);
          if (sb.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = sb.pop_front();
            check("write_data", int'(lcd_data), int'(e.data));
            check("write_rs", int'(lcd_rs), int'(e.rs));
            if (e.rise >= 0) check("en_rise_cycle", cyc, e.rise);
          end
        end else if (lcd_en) begin
          width++;
          if (lcd_data != cur_data || lcd_rs != cur_rs) stab_bad++;
        end else if (in_pulse) begin
          in_pulse = 0;
          check("en_width", width, EN_CYC);
          if (lcd_data != cur_data || lcd_rs != cur_rs) stab_bad++;
        end
      end
    end
  end

  task automatic push_init();
    sb.push_back(exp_t'{1'b0, 8'h38, -1});
    sb.push_back(exp_t'{1'b0, 8'h0C, -1});
    sb.push_back(exp_t'{1'b0, 8'h01, -1});
    sb.push_back(exp_t'{1'b0, 8'h06, -1});
  endtask

  // Called at a negedge with reset just released.
  task automatic wait_init();
    int n = 0;
    int ready_bad = 0;
    while (!init_done && n < 2000) begin
      if (bus.req_ready) ready_bad++;
      @(negedge clk);
      n++;
    end
    check("init_done", int'(init_done), 1);
    check("ready_during_init", ready_bad, 0);
    check("idle_not_busy", int'(busy), 0);
    check("init_queue_drained", sb.size(), 0);
  endtask

  // Called at a negedge; returns at a negedge with req_valid low.
  task automatic send_req(input logic r, input logic [7:0] d, input bit keep_valid);
    int n = 0;
    int acc_edge, lat;
    bus.req_valid = 1'b1;
    bus.req_rs    = r;
    bus.req_data  = d;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    lat = model_accept(r, d, acc_edge);
    @(negedge clk);
    // Keeping valid high with junk while not ready must be ignored.
    if (keep_valid) begin
      bus.req_rs   = 1'($urandom_range(0, 1));
      bus.req_data = 8'($urandom_range(0, 255));
    end else begin
      bus.req_valid = 1'b0;
    end
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_return_cycle", cyc, acc_edge + lat);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] d;
    logic r;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_en", int'(lcd_en), 0);
    check("reset_data", int'(lcd_data), 0);
    check("reset_rs", int'(lcd_rs), 0);
    check("reset_init_done", int'(init_done), 0);
    check("reset_ready", int'(bus.req_ready), 0);
    check("reset_busy", int'(busy), 1);

    push_init();
    reset = 1'b0;
    wait_init();

    // Single character.
    send_req(1'b1, 8'h48, 1'b0);

    // Home the cursor, then two full lines of 'A'..'P'.
    send_req(1'b0, 8'h80, 1'b0);
    for (int i = 0; i < 32; i++) send_req(1'b1, 8'h41 + 8'(i % 16), 1'($urandom_range(0, 1)));

    // Clear mid-line, then a full line.
    for (int i = 0; i < 5; i++) send_req(1'b1, 8'h30 + 8'(i), 1'b0);
    send_req(1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 16; i++) send_req(1'b1, 8'h61 + 8'(i), 1'b1);

    // Explicit cursor positioning near the line end.
    send_req(1'b0, 8'h8E, 1'b0);
    for (int i = 0; i < 3; i++) send_req(1'b1, 8'h5A, 1'b0);
    send_req(1'b0, 8'hCF, 1'b0);
    send_req(1'b1, 8'h7A, 1'b1);
    send_req(1'b0, 8'h02, 1'b0);

    // Random traffic with idle gaps and held valid.
    for (int i = 0; i < 150; i++) begin
      r = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       d = 8'($urandom_range(1, 3));
        1:       d = 8'h80 | 8'($urandom_range(0, 127));
        default: d = 8'($urandom_range(0, 255));
      endcase
      send_req(r, d, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of an en pulse for 0x41.
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h41;
    sb.push_back(exp_t'{1'b1, 8'h41, cyc + 3});
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pulse_before_reset", int'(lcd_en), 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_drops_en", int'(lcd_en), 0);
    check("reset_clears_init_done", int'(init_done), 0);
    check("reset_clears_ready", int'(bus.req_ready), 0);
    check("reset_clears_data", int'(lcd_data), 0);
    sb.delete();
    m_col  = 0;
    m_line = 0;
    push_init();
    @(negedge clk);
    reset = 1'b0;
    wait_init();

    for (int i = 0; i < 17; i++) send_req(1'b1, 8'h20 + 8'(i), 1'b1);

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", sb.size(), 0);
    check("rw_always_zero", rw_bad, 0);
    check("bus_stable_during_pulse", stab_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter PWR_WAIT, default 8: cycles waited after reset before the first init command.
REQ-002 SHALL have parameter SETUP_CYC, default 1: cycles rs/data are stable before en rises.
REQ-003 SHALL have parameter EN_CYC, default 2: en high width in cycles.
REQ-004 SHALL have parameter HOLD_CYC, default 4: cycles after en falls for normal transactions.
REQ-005 SHALL have parameter LONG_WAIT, default 16: cycles after en falls for clear (0x01) and home (0x02/0x03) commands.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1: host request present.
REQ-009 SHALL have port req_rs, input, 1: 1 = character, 0 = command.
REQ-010 SHALL have port req_data, input, 8: character code or command byte.
REQ-011 SHALL have port req_ready, output, 1: request accepted on clk edge when req_valid && req_ready.
REQ-012 SHALL have port data, output, 8: LCD data bus.
REQ-013 SHALL have port rs, output, 1: LCD register select.
REQ-014 SHALL have port rw, output, 1: LCD read/write; constant 0.
REQ-015 SHALL have port en, output, 1: LCD enable strobe.
REQ-016 SHALL have port init_done, output, 1: init sequence complete.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 States SHALL be: PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WRAP.
REQ-019 PWRUP SHALL last PWR_WAIT cycles with en=0, then go to INIT.
REQ-020 INIT SHALL issue 0x38, 0x0C, 0x01, 0x06 in order, rs=0, each a full bus cycle; 0x01 uses LONG_WAIT.
REQ-021 On completion of the last init command, the block SHALL set init_done=1 and enter IDLE.
REQ-022 req_ready SHALL equal (state==IDLE && init_done); it SHALL be 0 during init.
REQ-023 A bus cycle SHALL follow acceptance: SETUP (en=0, SETUP_CYC cycles), then PULSE (en=1, EN_CYC cycles), then HOLD (en=0, HOLD_CYC or LONG_WAIT cycles), then IDLE.
REQ-024 rs/data SHALL change only on entry to SETUP and SHALL hold stable through HOLD; IDLE retains the last values.
REQ-025 Latency: for acceptance at edge N, en SHALL rise at edge N+1+SETUP_CYC; req_ready SHALL reassert at edge N+1+SETUP_CYC+EN_CYC+HOLD_CYC.
REQ-026 The block SHALL track cursor col (4-bit, 0..15) and line (1-bit).
REQ-027 Each character write SHALL increment col.
REQ-028 After the character at col 15, the block SHALL pass through WRAP and auto-issue a command bus cycle: 0xC0 if line=0, 0x80 if line=1; line SHALL toggle and col SHALL become 0; req_ready SHALL stay 0 until that cycle ends.
REQ-029 Host command 0x01/0x02/0x03 SHALL set col=0, line=0 and use LONG_WAIT.
REQ-030 Host command with bit7=1 SHALL set line=req_data[6], col=req_data[3:0].
REQ-031 Other host commands SHALL leave the cursor unchanged and use HOLD_CYC.
REQ-032 req_valid held while req_ready=0 SHALL be ignored; there is no queueing.
REQ-033 rw SHALL be 0 at all times.

Reset
REQ-034 On reset the block SHALL set state=PWRUP, en=0, rs=0, data=0x00, init_done=0, col=0, line=0 and clear all counters.
REQ-035 Reset mid-transaction SHALL drop en at that edge and restart the full init sequence; the interrupted request SHALL be discarded.

Structure
REQ-036 Shared package lcd_pkg SHALL hold the state enum, init command constants (0x38, 0x0C, 0x01, 0x06), line base addresses (0x80, 0xC0) and default timing values.
REQ-037 Sub-module lcd_bus_cycle SHALL implement the SETUP/PULSE/HOLD timing engine (start, byte, rs, long_wait in; done out); lcd_sequencer SHALL handle init, handshake and cursor.

Verification (default parameters)
REQ-038 Reset released at cycle 0 -> en pulses with data 0x38, 0x0C, 0x01, 0x06, rs=0, each en pulse 2 cycles wide; init_done=1 after the 0x06 hold; req_ready=0 throughout.
REQ-039 After init, char 'H' (0x48) with rs=1 -> en rises 2 cycles after acceptance with data=0x48, rs=1; req_ready returns 8 cycles after acceptance.
REQ-040 16 characters 'A'..'P' -> after 'P', automatic command 0xC0 (rs=0) before the 17th char is accepted; 32 characters -> 0x80 issued after the 32nd.
REQ-041 Command 0x01 mid-line -> hold lasts 16 cycles, col/line reset; next char followed by wrap only after 16 more chars.
REQ-042 Reset asserted during PULSE of char 0x41 -> en=0 next cycle, init sequence repeats, 0x41 never re-sent.
REQ-043 req_valid held high continuously -> exactly one acceptance per completed bus cycle; rw=0 at every sample.
